// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer.
//   ERR_W    : width of the per-character error field
//   PERR_BIT : parity-error position inside the error field
//   FERR_BIT : framing-error position inside the error field
//   IDLE_W   : width of the idle (receive timeout) counter, in bit-times
//   sat_inc  : saturating increment used by the idle counter
package uart_pkg;

  localparam int ERR_W    = 2;
  localparam int PERR_BIT = 1;
  localparam int FERR_BIT = 0;
  localparam int IDLE_W   = 8;

  function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered fill level.
// The head entry is visible on rd_data whenever empty is low; it reads as
// zero while empty so that nothing undefined reaches the outputs after reset.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wr_en, wr_data : push one entry (caller guarantees room, or a same-cycle pop)
//   rd_en          : pop the head (caller guarantees not empty)
//   rd_data        : head entry
//   level          : number of stored entries, 0..DEPTH
//   full, empty    : decoded from level
module sync_fifo_fwft #(
  parameter int DLY   = 1,
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  // Pointer wrap relies on DEPTH being a power of two; other values are
  // not supported and simply elaborate this empty marker block.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DLY < 0)) begin : g_bad_param
  end

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is intentionally not reset; only pointers and level are.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive buffer: queues characters (with parity/framing flags) from
// the UART receiver and presents them first-word-fall-through to a consumer.
// Also provides overrun detection, a fill-level watermark interrupt and an
// optional idle-timeout interrupt.
//
// Build option: define UART_RX_TIMEOUT_EN to include the idle-timeout logic.
// Without it irq_to_o is tied low and br_en_i/to_bits_i are ignored.
//
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   br_en_i               : one pulse per bit-time (timeout time base)
//   chr_data_i/vld/perr/ferr : incoming character and its error flags
//   rx_data_o, rx_err_o   : head character and its {perr,ferr}
//   rx_vld_o, rx_rdy_i    : head valid / consumer ready (pop on both high)
//   wm_thr_i              : watermark threshold, 0 disables
//   to_bits_i             : idle timeout in bit-times, 0 disables
//   ovr_clr_i             : clear sticky overrun flag
//   level_o, full_o, empty_o : FIFO status
//   ovr_o, irq_wm_o, irq_to_o, irq_o : overrun flag and interrupts
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DLY        = 1,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  br_en_i,
  input  logic [DATA_WIDTH-1:0] chr_data_i,
  input  logic                  chr_vld_i,
  input  logic                  chr_perr_i,
  input  logic                  chr_ferr_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic [ERR_W-1:0]      rx_err_o,
  output logic                  rx_vld_o,
  input  logic                  rx_rdy_i,
  input  logic [AW:0]           wm_thr_i,
  input  logic [7:0]            to_bits_i,
  input  logic                  ovr_clr_i,
  output logic [AW:0]           level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ovr_o,
  output logic                  irq_wm_o,
  output logic                  irq_to_o,
  output logic                  irq_o
);

  localparam int EW = ERR_W + DATA_WIDTH;

  logic [ERR_W-1:0] chr_err;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head_entry;
  logic             pop;
  logic             wr_en;
  logic             drop;

  always_comb begin
    chr_err = '0;
    if (chr_vld_i) begin
      chr_err[PERR_BIT] = chr_perr_i;
      chr_err[FERR_BIT] = chr_ferr_i;
    end
  end

  assign wr_entry = {chr_err, chr_data_i};

  assign pop   = !empty_o && rx_rdy_i;
  // A full FIFO still accepts a character when the head leaves the same cycle.
  assign wr_en = chr_vld_i && (!full_o || pop);
  assign drop  = chr_vld_i && full_o && !pop;

  sync_fifo_fwft #(
    .DLY   (DLY),
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_entry),
    .level   (level_o),
    .full    (full_o),
    .empty   (empty_o)
  );

  assign rx_vld_o  = !empty_o;
  assign rx_data_o = head_entry[DATA_WIDTH-1:0];
  assign rx_err_o  = head_entry[EW-1 -: ERR_W];

  // Overrun: a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_o <= 1'b0;
    end else if (drop) begin
      ovr_o <= 1'b1;
    end else if (ovr_clr_i) begin
      ovr_o <= 1'b0;
    end
  end

  assign irq_wm_o = (wm_thr_i != '0) && (level_o >= wm_thr_i);

`ifdef UART_RX_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_cnt_nxt;
  logic              irq_to_q;
  logic              irq_to_nxt;

  // Idle time is counted only while data sits unread; any FIFO activity
  // restarts it. The interrupt is sticky until the next write or pop.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    irq_to_nxt   = irq_to_q;
    if (wr_en || pop || empty_o) begin
      idle_cnt_nxt = '0;
    end else if (br_en_i) begin
      idle_cnt_nxt = sat_inc(idle_cnt);
    end
    if (wr_en || pop) begin
      irq_to_nxt = 1'b0;
    end else if ((to_bits_i != '0) && (idle_cnt_nxt == to_bits_i)) begin
      irq_to_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt <= '0;
      irq_to_q <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      irq_to_q <= irq_to_nxt;
    end
  end

  assign irq_to_o = irq_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^{br_en_i, to_bits_i};
  assign irq_to_o       = 1'b0;
`endif

  assign irq_o = irq_wm_o | irq_to_o | ovr_o;

endmodule

// File: tb/tb_uart_rx_buf.sv
module tb_uart_rx_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          br_en_i;
  logic [DW-1:0] chr_data_i;
  logic          chr_vld_i;
  logic          chr_perr_i;
  logic          chr_ferr_i;
  logic [DW-1:0] rx_data_o;
  logic [1:0]    rx_err_o;
  logic          rx_vld_o;
  logic          rx_rdy_i;
  logic [AW:0]   wm_thr_i;
  logic [7:0]    to_bits_i;
  logic          ovr_clr_i;
  logic [AW:0]   level_o;
  logic          full_o;
  logic          empty_o;
  logic          ovr_o;
  logic          irq_wm_o;
  logic          irq_to_o;
  logic          irq_o;

  uart_rx_buf #(
    .DLY        (1),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .br_en_i    (br_en_i),
    .chr_data_i (chr_data_i),
    .chr_vld_i  (chr_vld_i),
    .chr_perr_i (chr_perr_i),
    .chr_ferr_i (chr_ferr_i),
    .rx_data_o  (rx_data_o),
    .rx_err_o   (rx_err_o),
    .rx_vld_o   (rx_vld_o),
    .rx_rdy_i   (rx_rdy_i),
    .wm_thr_i   (wm_thr_i),
    .to_bits_i  (to_bits_i),
    .ovr_clr_i  (ovr_clr_i),
    .level_o    (level_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .ovr_o      (ovr_o),
    .irq_wm_o   (irq_wm_o),
    .irq_to_o   (irq_to_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queue of {perr, ferr, data} entries plus flags.
  logic [9:0] mq[$];
  bit         m_ovr;
  int         m_idle;
  bit         m_irq_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    logic [9:0] head;
    bit wm;
    lvl  = mq.size();
    head = (lvl != 0) ? mq[0] : 10'd0;
    wm   = (wm_thr_i != 0) && (lvl >= int'(wm_thr_i));
    chk({tag, ".level"}, 32'(level_o), 32'(lvl));
    chk({tag, ".full"},  32'(full_o),  32'(lvl == DEPTH));
    chk({tag, ".empty"}, 32'(empty_o), 32'(lvl == 0));
    chk({tag, ".vld"},   32'(rx_vld_o), 32'(lvl != 0));
    chk({tag, ".data"},  32'(rx_data_o), 32'(head[7:0]));
    chk({tag, ".err"},   32'(rx_err_o),  32'(head[9:8]));
    chk({tag, ".ovr"},   32'(ovr_o),     32'(m_ovr));
    chk({tag, ".irq_wm"}, 32'(irq_wm_o), 32'(wm));
    chk({tag, ".irq_to"}, 32'(irq_to_o), 32'(m_irq_to));
    chk({tag, ".irq"},   32'(irq_o),     32'(wm | m_irq_to | m_ovr));
  endtask

  // One clock cycle: drive inputs, advance model, check after the edge.
  task automatic step(input string tag, input bit vld, input logic [7:0] d,
                      input bit pe, input bit fe, input bit rdy,
                      input bit br, input bit clr);
    bit pop, full, wr, drop, was_empty;
    chr_vld_i  = vld;
    chr_data_i = d;
    chr_perr_i = pe;
    chr_ferr_i = fe;
    rx_rdy_i   = rdy;
    br_en_i    = br;
    ovr_clr_i  = clr;

    was_empty = (mq.size() == 0);
    full      = (mq.size() == DEPTH);
    pop       = !was_empty && rdy;
    wr        = vld && (!full || pop);
    drop      = vld && full && !pop;
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back({pe, fe, d});
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (TO_EN) begin
      if (wr || pop || was_empty) m_idle = 0;
      else if (br && m_idle < 255) m_idle++;
      if (wr || pop) m_irq_to = 1'b0;
      else if (to_bits_i != 0 && m_idle == int'(to_bits_i)) m_irq_to = 1'b1;
    end

    @(posedge clk_i);
    #1;
    chr_vld_i = 1'b0;
    br_en_i   = 1'b0;
    ovr_clr_i = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr    = 1'b0;
    m_idle   = 0;
    m_irq_to = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      step("fill", 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && mq.size() != 0; i++)
      step("drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    br_en_i    = 1'b0;
    chr_data_i = '0;
    chr_vld_i  = 1'b0;
    chr_perr_i = 1'b0;
    chr_ferr_i = 1'b0;
    rx_rdy_i   = 1'b0;
    wm_thr_i   = '0;
    to_bits_i  = '0;
    ovr_clr_i  = 1'b0;
    model_reset();

    #3;
    check_all("reset");
    #20;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("post_reset");

    // Single write with parity error, no consumer.
    step("wr_a5", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr_a5.lit_vld",  32'(rx_vld_o), 32'd1);
    chk("wr_a5.lit_data", 32'(rx_data_o), 32'hA5);
    chk("wr_a5.lit_err",  32'(rx_err_o), 32'd2);
    chk("wr_a5.lit_lvl",  32'(level_o), 32'd1);
    // Flags ignored when not valid.
    step("noval_err", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Overflow: 16 writes, one dropped, drain in order, then clear.
    fill(DEPTH);
    chk("ovf.lit_full", 32'(full_o), 32'd1);
    step("ovf_drop", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf.lit_ovr", 32'(ovr_o), 32'd1);
    chk("ovf.lit_lvl", 32'(level_o), 32'd16);
    drain();
    chk("ovf.lit_ovr_hold", 32'(ovr_o), 32'd1);
    step("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr.lit", 32'(ovr_o), 32'd0);

    // Full with simultaneous write and pop.
    fill(DEPTH);
    step("full_wrpop", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_wrpop.lit_lvl", 32'(level_o), 32'd16);
    chk("full_wrpop.lit_ovr", 32'(ovr_o), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++)
      step("tail_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tail.lit_data", 32'(rx_data_o), 32'h3C);
    chk("tail.lit_err",  32'(rx_err_o), 32'd1);
    drain();

    // Watermark at 4.
    wm_thr_i = 5'd4;
    fill(3);
    chk("wm3.lit", 32'(irq_wm_o), 32'd0);
    fill(1);
    chk("wm4.lit", 32'(irq_wm_o), 32'd1);
    step("wm_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wm_pop.lit", 32'(irq_wm_o), 32'd0);
    drain();
    wm_thr_i = '0;

    // Idle timeout of 10 bit-times.
    to_bits_i = 8'd10;
    fill(1);
    for (int i = 0; i < 9; i++) begin
      step("to_br", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("to_gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("to9.lit", 32'(irq_to_o), 32'd0);
    step("to_br10", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to10.lit", 32'(irq_to_o), 32'(TO_EN));
    step("to_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_pop.lit", 32'(irq_to_o), 32'd0);

    // Randomized traffic with varying consumer pressure and thresholds.
    for (int i = 0; i < 1500; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 250) % 2 == 0) ? 25 : 70;
      if (i % 100 == 0) begin
        wm_thr_i  = 5'($urandom_range(0, DEPTH));
        to_bits_i = 8'($urandom_range(0, 12));
      end
      step("rand", ($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0));
    end
    drain();
    step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wm_thr_i  = '0;
    to_bits_i = '0;

    // Asynchronous reset mid-stream at level 5 with overrun set.
    fill(DEPTH);
    step("pre_rst_drop", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++)
      step("pre_rst_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst.lit_lvl", 32'(level_o), 32'd5);
    chk("pre_rst.lit_ovr", 32'(ovr_o), 32'd1);
    rx_rdy_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("async_rst.lit_lvl", 32'(level_o), 32'd0);
    chk("async_rst.lit_vld", 32'(rx_vld_o), 32'd0);
    chk("async_rst.lit_ovr", 32'(ovr_o), 32'd0);
    check_all("async_rst");
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("after_rst");
    step("after_rst_wr", 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter DLY, default 1: register update delay in ns.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: character width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entry count, a power of 2 and at least 2.
REQ-004 SHALL have parameter AW = $clog2(FIFO_DEPTH), derived: pointer width.
REQ-005 SHALL have port clk_i  in  1: single clock; reset rst_n_i, asynchronous, active-low.
REQ-006 SHALL have port rst_n_i  in  1: async active-low reset.
REQ-007 SHALL have port br_en_i  in  1: one-cycle pulse per bit-time from the baud generator.
REQ-008 SHALL have port chr_data_i  in  DATA_WIDTH: character from the UART receiver.
REQ-009 SHALL have port chr_vld_i  in  1: one-cycle pulse, character complete.
REQ-010 SHALL have port chr_perr_i  in  1: parity error for this character, qualified by chr_vld_i.
REQ-011 SHALL have port chr_ferr_i  in  1: framing error for this character, qualified by chr_vld_i.
REQ-012 SHALL have port rx_data_o  out  DATA_WIDTH: FIFO head data.
REQ-013 SHALL have port rx_err_o  out  2: FIFO head {perr,ferr}.
REQ-014 SHALL have port rx_vld_o  out  1: head valid.
REQ-015 SHALL have port rx_rdy_i  in  1: consumer ready.
REQ-016 SHALL have port wm_thr_i  in  AW+1: watermark threshold; 0 disables.
REQ-017 SHALL have port to_bits_i  in  8: idle timeout in bit-times; 0 disables.
REQ-018 SHALL have port ovr_clr_i  in  1: clear overrun.
REQ-019 SHALL have outputs level_o (AW+1), full_o (1), empty_o (1), ovr_o (1), irq_wm_o (1), irq_to_o (1), irq_o (1).

Function
REQ-020 SHALL store {chr_perr_i, chr_ferr_i, chr_data_i} as one entry when chr_vld_i=1 and the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-021 SHALL present the head first-word-fall-through: rx_vld_o = !empty_o, with rx_data_o/rx_err_o valid whenever rx_vld_o=1.
REQ-022 SHALL pop exactly when rx_vld_o && rx_rdy_i; write-to-rx_vld_o latency SHALL be 1 cycle.
REQ-023 SHALL update level_o as a register: +1 on write only, -1 on pop only, unchanged on both; full_o = (level_o==FIFO_DEPTH), empty_o = (level_o==0).
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH with no gap or duplicate entry at wrap.
REQ-025 SHALL drop the character when chr_vld_i=1, full, and no pop; ovr_o SHALL set the next cycle, remain sticky, and clear on ovr_clr_i, with set winning over a simultaneous clear.
REQ-026 SHALL drive irq_wm_o = (wm_thr_i!=0) && (level_o >= wm_thr_i), combinational from level_o.
REQ-027 SHALL increment a saturating idle counter on br_en_i while !empty_o, clearing it on any write or pop, or when empty.
REQ-028 SHALL set irq_to_o when to_bits_i!=0 and the idle count equals to_bits_i; irq_to_o SHALL clear on the next pop or write.
REQ-029 SHALL drive irq_o = irq_wm_o | irq_to_o | ovr_o.
REQ-030 SHALL ignore chr_perr_i/chr_ferr_i when chr_vld_i=0.

Reset
REQ-031 SHALL, on rst_n_i low at any time including mid-transfer, discard all entries asynchronously: pointers=0, level_o=0, empty_o=1, full_o=0, rx_vld_o=0, ovr_o=0, irq_to_o=0, idle counter=0.
REQ-032 SHALL drive rx_data_o/rx_err_o to 0 after reset; storage array contents are not reset.

Configuration
REQ-033 SHALL compile the idle-timeout logic (REQ-027, REQ-028) only when UART_RX_TIMEOUT_EN is defined.
REQ-034 SHALL, without UART_RX_TIMEOUT_EN, tie irq_to_o to 0, leave to_bits_i and br_en_i unused, and keep all ports present.

Structure
REQ-035 SHALL place the error-field width (2), error bit positions (PERR=1, FERR=0), and the idle-counter width (8) in shared package uart_pkg.
REQ-036 SHALL implement storage, pointers, and level in one sub-module sync_fifo_fwft, instantiated once.

Verification
REQ-037 Write 0xA5 with perr=1, rx_rdy_i=0 -> next cycle rx_vld_o=1, rx_data_o=0xA5, rx_err_o=2'b10, level_o=1.
REQ-038 Write 16 chars, 1 more with no pop -> full_o=1, 17th dropped, ovr_o=1; drain -> 16 values in order; ovr_clr_i -> ovr_o=0.
REQ-039 Full FIFO with simultaneous write and pop -> level_o stays 16, ovr_o stays 0, new char appears at the tail.
REQ-040 wm_thr_i=4, write 4 chars -> irq_wm_o=1 at level 4; pop 1 -> irq_wm_o=0.
REQ-041 to_bits_i=10, 1 char, no pop -> irq_to_o=1 after the 10th br_en_i pulse; pop -> irq_to_o=0; without the macro irq_to_o stays 0.
REQ-042 Assert reset with level_o=5 mid-stream -> level_o=0, rx_vld_o=0, ovr_o=0 immediately.
